// File: rtl/pixel_scatter_buffer.sv
// Multi-lane pixel buffer: compacts up to LANES valid pixels per beat in lane
// order, optionally drops same-beat duplicates, and drains one pixel per cycle
// as a first-word-fall-through FIFO.
module pixel_scatter_buffer #(
  parameter int unsigned PX_W      = 32,
  parameter int unsigned LANES     = 8,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned LOG2DEPTH = 7,
  parameter int unsigned DEDUP     = 1
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [LANES*PX_W-1:0]  in_px,
  input  logic [LANES-1:0]       in_mask,
  input  logic                   in_rts,
  output logic                   in_rtr,
  output logic [PX_W-1:0]        out_data,
  output logic                   out_rts,
  input  logic                   out_rtr,
  output logic [LOG2DEPTH:0]     level,
  output logic [15:0]            dup_count
);

  typedef logic [LOG2DEPTH:0] cnt_t;

  // Highest occupancy that still leaves room for a full-width beat.
  localparam cnt_t LP_MAX_LVL = cnt_t'(DEPTH - LANES);

  logic [PX_W-1:0]      r_mem [DEPTH];
  logic [LOG2DEPTH-1:0] r_wr_ptr;
  logic [LOG2DEPTH-1:0] r_rd_ptr;
  cnt_t                 r_level;
  logic [15:0]          r_dup_count;

  logic [LANES-1:0]     w_dup;
  logic [LANES-1:0]     w_keep;
  cnt_t                 w_ofs [LANES];
  cnt_t                 w_k;
  cnt_t                 w_drop;
  logic                 w_push;
  logic                 w_pop;
  logic [16:0]          w_dup_sum;

  // Space check uses registered occupancy only, so a same-cycle pop never helps.
  assign in_rtr    = (r_level <= LP_MAX_LVL);
  assign out_rts   = (r_level != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign level     = r_level;
  assign dup_count = r_dup_count;
  assign w_push    = in_rts & in_rtr;
  assign w_pop     = out_rts & out_rtr;
  assign w_dup_sum = {1'b0, r_dup_count} + 17'(w_drop);

  // Duplicate detection, keep mask and per-lane compacted write offsets.
  always_comb begin
    w_dup  = '0;
    w_k    = '0;
    w_drop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = 0; j < i; j++) begin
        // A lane is a duplicate of any lower masked lane, kept or not.
        if (in_mask[j] && (in_px[j*PX_W +: PX_W] == in_px[i*PX_W +: PX_W]))
          w_dup[i] = 1'b1;
      end
    end
    if (DEDUP != 0)
      w_keep = in_mask & ~w_dup;
    else
      w_keep = in_mask;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_ofs[i] = w_k;
      w_k      = w_k + cnt_t'(w_keep[i]);
      w_drop   = w_drop + cnt_t'(in_mask[i] & ~w_keep[i]);
    end
  end

  // Pointer, occupancy and duplicate-counter state.
  always_ff @(posedge clk) begin
    if (rst_) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_dup_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LOG2DEPTH'(w_k);
        if (w_dup_sum > 17'h0FFFF)
          r_dup_count <= 16'hFFFF;
        else
          r_dup_count <= w_dup_sum[15:0];
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + (w_push ? w_k : '0) - cnt_t'(w_pop);
    end
  end

  // Scatter kept lanes into consecutive entries; storage itself is never cleared.
  always_ff @(posedge clk) begin
    if (!rst_ && w_push) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (w_keep[i])
          r_mem[r_wr_ptr + LOG2DEPTH'(w_ofs[i])] <= in_px[i*PX_W +: PX_W];
      end
    end
  end

endmodule

// File: tb/tb_pixel_scatter_buffer.sv
// Self-checking bench for pixel_scatter_buffer: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_pixel_scatter_buffer;

  localparam int PX_W      = 32;
  localparam int LANES     = 8;
  localparam int DEPTH     = 128;
  localparam int LOG2DEPTH = 7;
  localparam int DEDUP     = 1;

  logic                  clk = 1'b0;
  logic                  rst_;
  logic [LANES*PX_W-1:0] in_px;
  logic [LANES-1:0]      in_mask;
  logic                  in_rts;
  logic                  in_rtr;
  logic [PX_W-1:0]       out_data;
  logic                  out_rts;
  logic                  out_rtr;
  logic [LOG2DEPTH:0]    level;
  logic [15:0]           dup_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: pixel queue, duplicate counter, log of popped pixels.
  logic [PX_W-1:0] mq[$];
  logic [PX_W-1:0] plog[$];
  int unsigned     mdup = 0;
  bit              last_push;
  int unsigned     uid = 1;

  pixel_scatter_buffer #(
    .PX_W(PX_W), .LANES(LANES), .DEPTH(DEPTH), .LOG2DEPTH(LOG2DEPTH), .DEDUP(DEDUP)
  ) dut (
    .clk(clk), .rst_(rst_), .in_px(in_px), .in_mask(in_mask), .in_rts(in_rts),
    .in_rtr(in_rtr), .out_data(out_data), .out_rts(out_rts), .out_rtr(out_rtr),
    .level(level), .dup_count(dup_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Compare at negedge, then advance the model across the next posedge.
  task automatic cycle();
    bit                    c_push, c_pop, c_rst, d;
    logic [LANES*PX_W-1:0] c_px;
    logic [LANES-1:0]      c_mask;
    @(negedge clk);
    chk("level", level, mq.size());
    chk("out_rts", out_rts, mq.size() != 0);
    chk("in_rtr", in_rtr, (DEPTH - mq.size()) >= LANES);
    chk("dup_count", dup_count, mdup);
    chk("level_le_depth", level <= DEPTH, 1'b1);
    if (mq.size() != 0) chk("out_data", out_data, mq[0]);
    c_rst  = rst_;
    c_push = in_rts && ((DEPTH - mq.size()) >= LANES);
    c_pop  = out_rtr && (mq.size() != 0);
    c_px   = in_px;
    c_mask = in_mask;
    if (c_pop && !c_rst) plog.push_back(out_data);
    @(posedge clk);
    last_push = c_push && !c_rst;
    if (c_rst) begin
      mq.delete();
      mdup = 0;
    end else begin
      if (c_pop) void'(mq.pop_front());
      if (c_push) begin
        for (int i = 0; i < LANES; i++) begin
          if (c_mask[i]) begin
            d = 0;
            for (int j = 0; j < i; j++)
              if (c_mask[j] && c_px[j*PX_W +: PX_W] == c_px[i*PX_W +: PX_W]) d = 1;
            if (d && DEDUP != 0) begin
              if (mdup < 16'hFFFF) mdup++;
            end else begin
              mq.push_back(c_px[i*PX_W +: PX_W]);
            end
          end
        end
      end
    end
    #1;
  endtask

  // Present a beat until it is accepted (bounded), then drop in_rts.
  task automatic push_beat(input logic [LANES-1:0] m, input logic [LANES*PX_W-1:0] px);
    int n = 0;
    in_px   = px;
    in_mask = m;
    in_rts  = 1'b1;
    do begin
      cycle();
      n++;
    end while (!last_push && n < 400);
    if (!last_push) chk("push_timeout", 1'b0, 1'b1);
    in_rts = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_rtr = 1'b1;
    while (level != 0 && n < 400) begin
      cycle();
      n++;
    end
    if (level != 0) chk("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    cycle();
    rst_ = 1'b0;
    plog.delete();
  endtask

  function automatic logic [LANES*PX_W-1:0] uniq_beat();
    logic [LANES*PX_W-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      v[i*PX_W +: PX_W] = PX_W'(uid);
      uid++;
    end
    return v;
  endfunction

  logic [LANES*PX_W-1:0] bv;
  logic [PX_W-1:0]       exp4[4];

  initial begin
    rst_ = 1'b1; in_px = '0; in_mask = '0; in_rts = 1'b0; out_rtr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b0;
    // 1: reset state, then mid-operation reset.
    chk("rst_in_rtr", in_rtr, 1'b1);
    chk("rst_out_rts", out_rts, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_dup", dup_count, 0);
    push_beat(8'h1F, uniq_beat());
    chk("t1_level5", level, 5);
    do_reset();
    chk("t1_rst_level", level, 0);
    chk("t1_rst_out_rts", out_rts, 1'b0);

    // 2: sparse mask compaction.
    for (int i = 0; i < LANES; i++) bv[i*PX_W +: PX_W] = PX_W'(32'h100 + i);
    out_rtr = 1'b1;
    push_beat(8'hA5, bv);
    repeat (6) cycle();
    chk("t2_count", plog.size(), 4);
    exp4 = '{32'h100, 32'h102, 32'h105, 32'h107};
    for (int i = 0; i < 4; i++) if (i < plog.size()) chk("t2_order", plog[i], exp4[i]);
    chk("t2_empty", out_rts, 1'b0);

    // 3: duplicate removal {A,B,A,C,B,D,D,A}.
    do_reset();
    exp4 = '{32'hA, 32'hB, 32'hC, 32'hD};
    bv = {32'hA, 32'hD, 32'hD, 32'hB, 32'hC, 32'hA, 32'hB, 32'hA};
    out_rtr = 1'b1;
    push_beat(8'hFF, bv);
    repeat (6) cycle();
    chk("t3_dup", dup_count, 4);
    chk("t3_count", plog.size(), 4);
    for (int i = 0; i < 4; i++) if (i < plog.size()) chk("t3_order", plog[i], exp4[i]);

    // 4: fill to DEPTH with no draining, then free one beat of space.
    do_reset();
    out_rtr = 1'b0;
    for (int b = 0; b < 16; b++) push_beat(8'hFF, uniq_beat());
    chk("t4_full_level", level, 128);
    chk("t4_full_rtr", in_rtr, 1'b0);
    out_rtr = 1'b1;
    repeat (8) cycle();
    out_rtr = 1'b0;
    chk("t4_level120", level, 120);
    chk("t4_rtr_back", in_rtr, 1'b1);
    drain();

    // 5: pointer wrap from 125.
    do_reset();
    out_rtr = 1'b1;
    for (int b = 0; b < 15; b++) push_beat(8'hFF, uniq_beat());
    push_beat(8'h1F, uniq_beat());
    drain();
    plog.delete();
    bv = uniq_beat();
    push_beat(8'hFF, bv);
    drain();
    chk("t5_count", plog.size(), 8);
    for (int i = 0; i < 8; i++) if (i < plog.size()) chk("t5_order", plog[i], bv[i*PX_W +: PX_W]);

    // 6: empty beat handshake with a concurrent pop.
    do_reset();
    out_rtr = 1'b0;
    bv = uniq_beat();
    push_beat(8'h07, bv);
    out_rtr = 1'b1;
    push_beat(8'h00, uniq_beat());
    chk("t6_level2", level, 2);
    drain();
    chk("t6_count", plog.size(), 3);
    for (int i = 0; i < 3; i++) if (i < plog.size()) chk("t6_order", plog[i], bv[i*PX_W +: PX_W]);

    // Random traffic with small pixel alphabet to exercise dedup and wrap.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < LANES; i++) in_px[i*PX_W +: PX_W] = PX_W'($urandom_range(0, 5));
      in_mask = LANES'($urandom);
      in_rts  = ($urandom_range(0, 3) != 0);
      out_rtr = ($urandom_range(0, 2) != 0);
      rst_    = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst_ = 1'b0; in_rts = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
